intersection_sequencer: RTL and testbench
=========================================

INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

Interface
REQ-001 Parameter GREEN_CYC, default 32: green phase duration in enabled cycles.
REQ-002 Parameter YELLOW_CYC, default 8: yellow phase duration in enabled cycles.
REQ-003 Parameter ALLRED_CYC, default 4: all-red clearance duration in enabled cycles.
REQ-004 Parameter WALK_CYC, default 16: pedestrian walk duration in enabled cycles.
REQ-005 Parameter CNT_W, default 8: phase counter width; every duration SHALL be in 1..2^CNT_W, checked at elaboration.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 enable  in  1  advance timing when 1; freeze counter and state when 0.
REQ-009 ped_req  in  1  pedestrian request, level-sampled each cycle.
REQ-010 ped_ack  out  1  one-cycle pulse when a request is accepted.
REQ-011 a_red, a_yellow, a_green  out  1 each  road A lamps, exactly one high.
REQ-012 b_red, b_yellow, b_green  out  1 each  road B lamps, exactly one high.
REQ-013 walk  out  1  pedestrian walk lamp.

Function
REQ-014 States: CLR_A (all red, A next), A_GREEN, A_YELLOW, CLR_B (all red, B next), B_GREEN, B_YELLOW, WALK.
REQ-015 Phase counter SHALL clear to 0 on every state change, increment by 1 per enabled cycle, and hold when enable=0.
REQ-016 A phase SHALL end when enable=1 and counter = duration-1; with enable held high each phase lasts exactly its duration in cycles.
REQ-017 Transitions: CLR_A->A_GREEN, A_GREEN->A_YELLOW, A_YELLOW->CLR_B, CLR_B->B_GREEN, B_GREEN->B_YELLOW, B_YELLOW->CLR_A.
REQ-018 When a clearance phase ends with ped_pending=1, the next state SHALL be WALK instead of the green, and ped_pending SHALL clear.
REQ-019 A return-road register SHALL record the green skipped; WALK end SHALL go to that road's GREEN.
REQ-020 ped_pending SHALL set, and ped_ack pulse for one cycle, when ped_req=1, ped_pending=0 and state is not WALK; otherwise ped_req is ignored without ack.
REQ-021 ped_req SHALL be accepted regardless of enable.
REQ-022 Lamps SHALL be a registered decode of the state: reds high in CLR_A, CLR_B and WALK; walk high only in WALK.
REQ-023 No cycle SHALL have any A non-red lamp and any B non-red lamp high together, nor walk with any green or yellow.
REQ-024 Lamps SHALL change in the same cycle the state register changes, with no combinational path from inputs to lamps.
REQ-025 An illegal state encoding SHALL return to CLR_A on the next clock, whatever enable is.

Reset
REQ-026 While reset_n=0: state CLR_A, counter 0, ped_pending 0, return-road A, ped_ack 0, a_red=b_red=1, other lamps and walk 0.
REQ-027 Reset assertion mid-phase SHALL take effect immediately (asynchronous) and discard any pending request.
REQ-028 Release SHALL be synchronised to clk; the first enabled edge after release counts as counter cycle 0 of CLR_A.

Structure
REQ-029 Package intersection_pkg SHALL hold the state enum and the default duration constants.
REQ-030 Sub-module phase_timer SHALL hold the counter: inputs enable, clear and duration; output done.
REQ-031 The top level SHALL hold the state register, pedestrian latch, return-road register and lamp decode.

Verification
REQ-032 Reset release, enable=1 continuously, no ped_req -> CLR_A 4, A_GREEN 32, A_YELLOW 8, CLR_B 4, B_GREEN 32, B_YELLOW 8; period 88 cycles.
REQ-033 ped_req 1-cycle pulse during A_GREEN cycle 10 -> ped_ack next cycle; after A_YELLOW and CLR_B, WALK 16 cycles, then B_GREEN.
REQ-034 enable=0 for 20 cycles mid A_GREEN -> lamps frozen, A_GREEN total length still 32 enabled cycles.
REQ-035 ped_req held high through WALK -> no ack during WALK; ack on the first cycle after WALK exits.
REQ-036 reset_n asserted at B_YELLOW cycle 3 with request pending -> lamps immediately all red, pending cleared, sequence restarts from CLR_A.
REQ-037 All tests: assertion that REQ-023 holds every cycle, plus lamp one-hot per road.

Source files
------------

// File: rtl/intersection_pkg.sv
// Intersection sequencer shared definitions.
// Purpose : state encoding, lamp bundle type, default phase durations and
//           the state-to-lamp decode used by the sequencer top level.
// Ports   : none (package).
package intersection_pkg;

    localparam int DEF_GREEN_CYC  = 32;
    localparam int DEF_YELLOW_CYC = 8;
    localparam int DEF_ALLRED_CYC = 4;
    localparam int DEF_WALK_CYC   = 16;
    localparam int DEF_CNT_W      = 8;

    // Encoding 3'd7 is unused and treated as illegal (recovers to CLR_A).
    typedef enum logic [2:0] {
        CLR_A    = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        CLR_B    = 3'd3,
        B_GREEN  = 3'd4,
        B_YELLOW = 3'd5,
        WALK     = 3'd6
    } state_t;

    typedef struct packed {
        logic a_red;
        logic a_yellow;
        logic a_green;
        logic b_red;
        logic b_yellow;
        logic b_green;
        logic walk;
    } lamps_t;

    localparam lamps_t LAMPS_ALL_RED = '{
        a_red: 1'b1, a_yellow: 1'b0, a_green: 1'b0,
        b_red: 1'b1, b_yellow: 1'b0, b_green: 1'b0,
        walk: 1'b0
    };

    // Only one road is ever released; anything unexpected shows all red.
    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l = LAMPS_ALL_RED;
        case (s)
            A_GREEN:  begin l.a_red = 1'b0; l.a_green  = 1'b1; end
            A_YELLOW: begin l.a_red = 1'b0; l.a_yellow = 1'b1; end
            B_GREEN:  begin l.b_red = 1'b0; l.b_green  = 1'b1; end
            B_YELLOW: begin l.b_red = 1'b0; l.b_yellow = 1'b1; end
            WALK:     l.walk = 1'b1;
            default:  ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_sequencer_if.sv
// Intersection sequencer control/lamp bundle.
// Purpose : groups the controller-facing signals of the sequencer.
// Ports   : enable, ped_req (controller -> sequencer);
//           ped_ack, a_red/a_yellow/a_green, b_red/b_yellow/b_green, walk
//           (sequencer -> controller/lamps).
// Modports: master = controller side, slave = sequencer side.
interface intersection_sequencer_if;
    logic enable;
    logic ped_req;
    logic ped_ack;
    logic a_red;
    logic a_yellow;
    logic a_green;
    logic b_red;
    logic b_yellow;
    logic b_green;
    logic walk;

    modport master (
        output enable, ped_req,
        input  ped_ack, a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk
    );

    modport slave (
        input  enable, ped_req,
        output ped_ack, a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk
    );
endinterface

// File: rtl/intersection_sequencer_phase_timer.sv
// Phase timer for the intersection sequencer.
// Purpose : counts enabled cycles within the current phase.
// Ports   : clk, rst_n (async active-low), enable (count when 1),
//           clear (restart at 0, wins over enable), duration (phase length,
//           1..2^CNT_W), done (this enabled cycle is the last of the phase).
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W:0]   duration,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W:0]   last_count;

    // duration is one bit wider so a full 2^CNT_W phase is expressible.
    assign last_count = duration - (CNT_W + 1)'(1);
    assign done       = enable && ({1'b0, count_reg} == last_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/intersection_sequencer.sv
// Two-road intersection sequencer with pedestrian walk phase.
// Purpose : cycles CLR_A -> A_GREEN -> A_YELLOW -> CLR_B -> B_GREEN ->
//           B_YELLOW -> CLR_A, inserting WALK after a clearance when a
//           pedestrian request is pending, then resuming the skipped green.
// Ports   : clk, reset_n (async assert, clk-synchronised release),
//           bus (slave modport): enable, ped_req in; ped_ack, lamps, walk out.
module intersection_sequencer
    import intersection_pkg::*;
#(
    parameter int GREEN_CYC  = DEF_GREEN_CYC,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int WALK_CYC   = DEF_WALK_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic                      clk,
    input logic                      reset_n,
    intersection_sequencer_if.slave  bus
);

    localparam int DUR_W   = CNT_W + 1;
    localparam int DUR_MAX = 1 << CNT_W;

    if (GREEN_CYC < 1 || GREEN_CYC > DUR_MAX || YELLOW_CYC < 1 || YELLOW_CYC > DUR_MAX ||
        ALLRED_CYC < 1 || ALLRED_CYC > DUR_MAX || WALK_CYC < 1 || WALK_CYC > DUR_MAX)
    begin : g_bad_duration
        $error("intersection_sequencer: every duration must lie in 1..2^CNT_W");
    end

    // Reset asserts immediately, releases two clk edges later.
    logic [1:0] rst_sync_reg;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_reg[1];

    state_t           state_reg, state_next;
    logic             ped_pending_reg, ped_pending_next;
    logic             return_b_reg, return_b_next;
    logic             ped_ack_reg;
    lamps_t           lamps_reg;
    logic             accept;
    logic             phase_done;
    logic             phase_clear;
    logic [DUR_W-1:0] duration;

    always_comb begin
        case (state_reg)
            CLR_A, CLR_B:       duration = DUR_W'(ALLRED_CYC);
            A_GREEN, B_GREEN:   duration = DUR_W'(GREEN_CYC);
            A_YELLOW, B_YELLOW: duration = DUR_W'(YELLOW_CYC);
            WALK:               duration = DUR_W'(WALK_CYC);
            default:            duration = DUR_W'(1);
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n_int),
        .enable   (bus.enable),
        .clear    (phase_clear),
        .duration (duration),
        .done     (phase_done)
    );

    always_comb begin
        state_next       = state_reg;
        ped_pending_next = ped_pending_reg;
        return_b_next    = return_b_reg;
        // Requests are sampled independent of enable; pending and WALK block them.
        accept = bus.ped_req && !ped_pending_reg && (state_reg != WALK);
        if (accept) begin
            ped_pending_next = 1'b1;
        end
        case (state_reg)
            CLR_A: if (phase_done) begin
                if (ped_pending_reg) begin
                    state_next       = WALK;
                    ped_pending_next = 1'b0;
                    return_b_next    = 1'b0;
                end else begin
                    state_next = A_GREEN;
                end
            end
            A_GREEN:  if (phase_done) state_next = A_YELLOW;
            A_YELLOW: if (phase_done) state_next = CLR_B;
            CLR_B: if (phase_done) begin
                if (ped_pending_reg) begin
                    state_next       = WALK;
                    ped_pending_next = 1'b0;
                    return_b_next    = 1'b1;
                end else begin
                    state_next = B_GREEN;
                end
            end
            B_GREEN:  if (phase_done) state_next = B_YELLOW;
            B_YELLOW: if (phase_done) state_next = CLR_A;
            WALK:     if (phase_done) state_next = return_b_reg ? B_GREEN : A_GREEN;
            default:  state_next = CLR_A;
        endcase
    end

    // Any state change restarts the phase count, including illegal recovery.
    assign phase_clear = (state_next != state_reg);

    // Lamps decode the next state so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg       <= CLR_A;
            ped_pending_reg <= 1'b0;
            return_b_reg    <= 1'b0;
            ped_ack_reg     <= 1'b0;
            lamps_reg       <= LAMPS_ALL_RED;
        end else begin
            state_reg       <= state_next;
            ped_pending_reg <= ped_pending_next;
            return_b_reg    <= return_b_next;
            ped_ack_reg     <= accept;
            lamps_reg       <= decode_lamps(state_next);
        end
    end

    assign bus.ped_ack  = ped_ack_reg;
    assign bus.a_red    = lamps_reg.a_red;
    assign bus.a_yellow = lamps_reg.a_yellow;
    assign bus.a_green  = lamps_reg.a_green;
    assign bus.b_red    = lamps_reg.b_red;
    assign bus.b_yellow = lamps_reg.b_yellow;
    assign bus.b_green  = lamps_reg.b_green;
    assign bus.walk     = lamps_reg.walk;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Testbench for intersection_sequencer with default durations.
// Purpose : directed scenarios for the normal cycle, pedestrian walk,
//           enable freeze, held requests and mid-phase reset, plus a
//           per-cycle lamp safety monitor.
// Ports   : none (top-level bench).
module tb_intersection_sequencer;

    localparam logic [6:0] P_CLR  = 7'b1001000;
    localparam logic [6:0] P_AG   = 7'b0011000;
    localparam logic [6:0] P_AY   = 7'b0101000;
    localparam logic [6:0] P_BG   = 7'b1000010;
    localparam logic [6:0] P_BY   = 7'b1000100;
    localparam logic [6:0] P_WALK = 7'b1001001;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 0;
    logic [6:0] lamps;

    intersection_sequencer_if bus();

    intersection_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign lamps = {bus.a_red, bus.a_yellow, bus.a_green,
                    bus.b_red, bus.b_yellow, bus.b_green, bus.walk};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamp safety: one lamp per road, never both roads released, walk only with all red.
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if ($onehot({bus.a_red, bus.a_yellow, bus.a_green}) !== 1'b1 ||
                $onehot({bus.b_red, bus.b_yellow, bus.b_green}) !== 1'b1 ||
                ((bus.a_yellow | bus.a_green) && (bus.b_yellow | bus.b_green)) ||
                (bus.walk && (bus.a_yellow | bus.a_green | bus.b_yellow | bus.b_green))) begin
                errors++;
                $display("FAIL lamp_safety: lamps=%b not a safe pattern", lamps);
            end
        end
    end

    task automatic apply_reset();
        reset_n     = 1'b0;
        bus.enable  = 1'b0;
        bus.ped_req = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_pattern(input logic [6:0] pat, output bit found);
        int guard;
        guard = 0;
        while (lamps !== pat && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        found = (lamps === pat);
    endtask

    // Counts negedge samples while the pattern holds; returns at the first
    // sample of the following phase.
    task automatic run_phase(input logic [6:0] pat, output int len);
        bit found;
        wait_pattern(pat, found);
        len = 0;
        if (!found) begin
            len = -1;
        end else begin
            while (lamps === pat && len < 300) begin
                len++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.enable  = 1'b1;
        bus.ped_req = 1'b1;
        @(negedge clk);
        mon_on = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (lamps !== P_CLR) begin
                errors++;
                $display("FAIL reset_lamps: got %b expected %b", lamps, P_CLR);
            end
            checks++;
            if (bus.ped_ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_ack: got %b expected 0", bus.ped_ack);
            end
        end
        bus.ped_req = 1'b0;
        reset_n     = 1'b1;
    endtask

    task automatic test_normal_cycle();
        int len, total;
        int exp_len [6] = '{32, 8, 4, 32, 8, 4};
        logic [6:0] pats [6];
        pats = '{P_AG, P_AY, P_CLR, P_BG, P_BY, P_CLR};
        apply_reset();
        bus.enable = 1'b1;
        total = 0;
        for (int i = 0; i < 6; i++) begin
            run_phase(pats[i], len);
            total += len;
            checks++;
            if (len != exp_len[i]) begin
                errors++;
                $display("FAIL normal_phase%0d: length %0d expected %0d", i, len, exp_len[i]);
            end
        end
        checks++;
        if (total != 88) begin
            errors++;
            $display("FAIL normal_period: got %0d expected 88", total);
        end
        checks++;
        if (lamps !== P_AG) begin
            errors++;
            $display("FAIL normal_wrap: got %b expected %b", lamps, P_AG);
        end
    endtask

    task automatic test_ped_walk();
        int len;
        bit found;
        apply_reset();
        bus.enable = 1'b1;
        wait_pattern(P_AG, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL walk_reach_green: lamps %b expected %b", lamps, P_AG);
        end
        repeat (10) @(negedge clk);
        bus.ped_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ped_ack !== 1'b1) begin
            errors++;
            $display("FAIL walk_ack: got %b expected 1", bus.ped_ack);
        end
        bus.ped_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            errors++;
            $display("FAIL walk_ack_pulse: got %b expected 0", bus.ped_ack);
        end
        run_phase(P_AG, len);
        checks++;
        if (len != 20) begin errors++; $display("FAIL walk_green_rest: got %0d expected 20", len); end
        run_phase(P_AY, len);
        checks++;
        if (len != 8) begin errors++; $display("FAIL walk_yellow: got %0d expected 8", len); end
        run_phase(P_CLR, len);
        checks++;
        if (len != 4) begin errors++; $display("FAIL walk_clear: got %0d expected 4", len); end
        checks++;
        if (lamps !== P_WALK) begin
            errors++;
            $display("FAIL walk_entry: got %b expected %b", lamps, P_WALK);
        end
        run_phase(P_WALK, len);
        checks++;
        if (len != 16) begin errors++; $display("FAIL walk_length: got %0d expected 16", len); end
        checks++;
        if (lamps !== P_BG) begin
            errors++;
            $display("FAIL walk_return: got %b expected %b", lamps, P_BG);
        end
        run_phase(P_BG, len);
        checks++;
        if (len != 32) begin errors++; $display("FAIL walk_b_green: got %0d expected 32", len); end
    endtask

    task automatic test_enable_freeze();
        int len;
        bit found;
        apply_reset();
        bus.enable = 1'b1;
        wait_pattern(P_AG, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL freeze_reach_green: lamps %b expected %b", lamps, P_AG);
        end
        repeat (10) @(negedge clk);
        bus.enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (lamps !== P_AG) begin
                errors++;
                $display("FAIL freeze_lamps: cycle %0d got %b expected %b", i, lamps, P_AG);
            end
            if (i == 6) begin
                checks++;
                if (bus.ped_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL freeze_req_ack: got %b expected 1", bus.ped_ack);
                end
                bus.ped_req = 1'b0;
            end
            if (i == 5) bus.ped_req = 1'b1;
        end
        bus.enable = 1'b1;
        run_phase(P_AG, len);
        checks++;
        if (len != 22) begin errors++; $display("FAIL freeze_green_rest: got %0d expected 22", len); end
        run_phase(P_AY, len);
        checks++;
        if (len != 8) begin errors++; $display("FAIL freeze_yellow: got %0d expected 8", len); end
        run_phase(P_CLR, len);
        checks++;
        if (len != 4) begin errors++; $display("FAIL freeze_clear: got %0d expected 4", len); end
        checks++;
        if (lamps !== P_WALK) begin
            errors++;
            $display("FAIL freeze_walk_entry: got %b expected %b", lamps, P_WALK);
        end
    endtask

    task automatic test_ped_hold();
        int len, acks;
        apply_reset();
        bus.enable = 1'b1;
        wait_pattern(P_AG, acks[0]);
        bus.ped_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ped_ack !== 1'b1) begin
            errors++;
            $display("FAIL hold_first_ack: got %b expected 1", bus.ped_ack);
        end
        @(negedge clk);
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_repeat: got %b expected 0", bus.ped_ack);
        end
        run_phase(P_AG, len);
        checks++;
        if (len != 30) begin errors++; $display("FAIL hold_green_rest: got %0d expected 30", len); end
        run_phase(P_AY, len);
        run_phase(P_CLR, len);
        len  = 0;
        acks = 0;
        while (lamps === P_WALK && len < 100) begin
            len++;
            if (bus.ped_ack === 1'b1) acks++;
            @(negedge clk);
        end
        checks++;
        if (len != 16) begin errors++; $display("FAIL hold_walk_length: got %0d expected 16", len); end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL hold_walk_acks: got %0d expected 0", acks); end
        checks++;
        if (lamps !== P_BG) begin
            errors++;
            $display("FAIL hold_return: got %b expected %b", lamps, P_BG);
        end
        // Accepted during the first B_GREEN cycle, acknowledged one cycle later.
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack_timing: got %b expected 0", bus.ped_ack);
        end
        @(negedge clk);
        checks++;
        if (bus.ped_ack !== 1'b1) begin
            errors++;
            $display("FAIL hold_ack_after_walk: got %b expected 1", bus.ped_ack);
        end
        @(negedge clk);
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack_single: got %b expected 0", bus.ped_ack);
        end
        bus.ped_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int len, guard;
        bit found;
        apply_reset();
        bus.enable = 1'b1;
        wait_pattern(P_BG, found);
        bus.ped_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ped_ack !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ack: got %b expected 1", bus.ped_ack);
        end
        bus.ped_req = 1'b0;
        wait_pattern(P_BY, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rmid_reach_yellow: lamps %b expected %b", lamps, P_BY);
        end
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (lamps !== P_CLR) begin
            errors++;
            $display("FAIL rmid_lamps_immediate: got %b expected %b", lamps, P_CLR);
        end
        checks++;
        if (bus.ped_ack !== 1'b0) begin
            errors++;
            $display("FAIL rmid_ack_cleared: got %b expected 0", bus.ped_ack);
        end
        @(negedge clk);
        reset_n = 1'b1;
        guard = 0;
        while (lamps === P_CLR && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (lamps !== P_AG) begin
            errors++;
            $display("FAIL rmid_restart: got %b expected %b", lamps, P_AG);
        end
        run_phase(P_AG, len);
        checks++;
        if (len != 32) begin errors++; $display("FAIL rmid_green: got %0d expected 32", len); end
        run_phase(P_AY, len);
        run_phase(P_CLR, len);
        checks++;
        if (lamps !== P_BG) begin
            errors++;
            $display("FAIL rmid_pending_discarded: got %b expected %b", lamps, P_BG);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.enable  = 1'b0;
        bus.ped_req = 1'b0;
        test_reset();
        test_normal_cycle();
        test_ped_walk();
        test_enable_freeze();
        test_ped_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
